mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory between NUM_CORES processor cores in the multi-core multiplier.
- Sits between the cores' load/store ports and the shared data RAM. The RAM has 1-cycle registered read latency.
- Supports a lock so one core can hold the memory across several back-to-back accesses, e.g. a read-modify-write or a burst of matrix-element stores.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  NUM_CORES  per-core access request; held high until granted
- core_we  in  NUM_CORES  per-core write enable (1 = store, 0 = load)
- core_lock  in  NUM_CORES  per-core lock request; meaningful only while that core is granted
- core_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing as core_addr
- core_gnt  out  NUM_CORES  one-hot grant, combinational, same cycle as the access
- core_rvalid  out  NUM_CORES  one-hot, registered; load data valid for core i
- core_rdata  out  DATA_W  load data, broadcast to all cores; qualified by core_rvalid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read access

Behaviour:
- State:
  - ptr: index of the highest-priority core, log2(NUM_CORES) bits, reset 0.
  - owner: index of the locked core, plus flag locked, reset 0.
  - rv_q: NUM_CORES one-hot, reset 0.
- Grant (combinational, cycle T):
  - If locked and core_req[owner]: grant owner.
  - If locked and !core_req[owner]: grant nothing (memory idle).
  - If not locked: grant the first requesting core found searching ptr, ptr+1, ..., wrapping modulo NUM_CORES.
  - No requests: core_gnt = 0, mem_en = 0.
- Memory drive (cycle T): mem_en = |core_gnt; mem_we, mem_addr and mem_wdata are muxed from the granted core. With no grant, mem_we = 0 and mem_addr/mem_wdata = 0.
- Pointer update at edge T:
  - If a grant occurred and the grant was not due to the lock: ptr <= (winner+1) mod NUM_CORES.
  - Otherwise ptr is unchanged.
- Lock:
  - At edge T, if winner w has core_lock[w]=1: locked <= 1, owner <= w.
  - Lock is released at the edge of the owner's first granted access with core_lock=0, or any cycle where core_lock[owner]=0.
  - After release, ptr <= owner+1.
- Read return:
  - rv_q <= core_gnt & ~core_we at each edge. core_rvalid = rv_q.
  - core_rdata = mem_rdata, passed straight through; 1-cycle load latency.
- Writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back grants to different cores are allowed, and read returns pipeline.
- Core handshake: a core holds req/we/addr/wdata stable until it sees gnt=1. Its access completes at that edge. It may deassert req or present a new request in the next cycle.
- Simultaneous events:
  - A lock release and other pending requests in the same cycle: the owner still gets that cycle's grant. Round-robin resumes from the next cycle.
- Reset:
  - While rst=1: core_gnt = 0 and mem_en = 0, combinationally forced.
  - rv_q is cleared; a read issued in the cycle before reset returns no rvalid.
  - ptr = 0 and the lock is cleared.
- Invariants: core_gnt and core_rvalid are each one-hot or zero. mem_en = |core_gnt.

Test Plan:
- Single read:
  - Stimulus: reset, then core 2 requests a read at addr 0x0010 while memory holds 0x5A.
  - Required: core_gnt=0100 the same cycle, mem_en=1, mem_we=0, mem_addr=0x0010; next cycle core_rvalid=0100, core_rdata=0x5A.
- Round-robin fairness:
  - Stimulus: all 4 cores hold req continuously for 8 cycles, starting from ptr=0.
  - Required: grant order 0,1,2,3,0,1,2,3 with no idle cycles; rvalid follows one cycle behind each grant.
- Write path:
  - Stimulus: core 1 writes 0xC3 to 0x0100 and is granted; core 3 then reads 0x0100.
  - Required: the write cycle shows mem_we=1, mem_wdata=0xC3 and no rvalid; the read returns core_rvalid=1000, core_rdata=0xC3.
- Lock:
  - Stimulus: core 0 asserts lock for 3 accesses while cores 1–3 also request.
  - Required: core 0 is granted 3 consecutive cycles; after release the next grant goes to core 1.
- Lock idle:
  - Stimulus: core 2 is the lock owner, deasserts req for 2 cycles with lock=1, while core 0 requests.
  - Required: core_gnt=0 and mem_en=0 for those 2 cycles; core 0 is not granted until the lock is released.
- Reset mid-read:
  - Stimulus: core 3 is granted a read and rst is asserted the next cycle.
  - Required: core_rvalid stays 0, core_gnt=0 during reset; after reset the first grant goes to the lowest requesting index starting from 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NUM_CORES cores.
// Supports a per-core lock so one core can hold the memory across back-to-back accesses.
module mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES-1:0]        core_lock,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [NUM_CORES-1:0]   rv_q, rv_d;

    logic [NUM_CORES-1:0]   grant;
    logic [PTR_W-1:0]       win;
    logic [PTR_W-1:0]       cand;
    logic                   found;

    // Index arithmetic modulo NUM_CORES, which need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_CORES) begin
            sum = sum - NUM_CORES;
        end
        return sum[PTR_W-1:0];
    endfunction

    always_comb begin
        grant = '0;
        win   = '0;
        cand  = '0;
        found = 1'b0;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                // The owner keeps the memory; with no owner request the memory idles.
                if (core_req[owner_q]) begin
                    found = 1'b1;
                    win   = owner_q;
                end
            end else begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    cand = wrap_inc(ptr_q, k);
                    if (!found && core_req[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
            end
            if (found) begin
                grant[win] = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                mem_we    = core_we[i];
                mem_addr  = core_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        rv_d    = grant & ~core_we;
        if (state_q == ST_FREE) begin
            if (found) begin
                ptr_d = wrap_inc(win, 1);
                if (core_lock[win]) begin
                    state_d = ST_LOCKED;
                    owner_d = win;
                end
            end
        end else begin
            // Release takes effect at this edge; the owner still keeps this cycle's grant.
            if (!core_lock[owner_q]) begin
                state_d = ST_FREE;
                ptr_d   = wrap_inc(owner_q, 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FREE;
            ptr_q   <= '0;
            owner_q <= '0;
            rv_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            rv_q    <= rv_d;
        end
    end

    assign core_gnt    = grant;
    assign mem_en      = |grant;
    // A read granted just before reset must not return data while reset is held.
    assign core_rvalid = rst ? '0 : rv_q;
    assign core_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus hand-written lock/reset sequences,
// with load returns checked one cycle later through an expected queue.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int W  = N + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    core_req, core_we, core_lock;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_gnt, core_rvalid;
    logic [DW-1:0]   core_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic [DW-1:0]   mem [0:65535];
    logic            bd_we;
    logic [AW-1:0]   bd_addr;
    logic [DW-1:0]   bd_data;

    int              total = 0;
    int              bad   = 0;
    string           tag;
    logic [W-1:0]    exp_q[$];

    typedef struct packed {
        logic            rst;
        logic [N-1:0]    req;
        logic [N-1:0]    we;
        logic [N-1:0]    lock;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] wdata;
        logic [N-1:0]    gnt;
        logic [DW-1:0]   rd;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_lock  (core_lock),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port RAM with registered read, plus a back door for preloading.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic logic [N*AW-1:0] pa(input logic [AW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [N*DW-1:0] pd(input logic [DW-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic r, input logic [N-1:0] req, we, lock,
                                input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wdata,
                                input logic [N-1:0] gnt, input logic [DW-1:0] rd);
        vec_t v;
        v.rst = r; v.req = req; v.we = we; v.lock = lock;
        v.addr = addr; v.wdata = wdata; v.gnt = gnt; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // One cycle: drive, check combinational grant/memory side and the load return, advance.
    task automatic step(input logic r, input logic [N-1:0] req, we, lock,
                        input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wdata,
                        input logic [N-1:0] exp_gnt, input logic [DW-1:0] exp_rd);
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_we;
        logic [W-1:0]  e;
        rst = r; core_req = req; core_we = we; core_lock = lock;
        core_addr = addr; core_wdata = wdata;
        if (r) exp_q.delete();
        e_addr = '0; e_wd = '0; e_we = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) begin
                e_addr = addr[i*AW +: AW];
                e_wd   = wdata[i*DW +: DW];
                e_we   = we[i];
            end
        end
        @(negedge clk);
        chk("gnt", 64'(core_gnt), 64'(exp_gnt));
        chk("mem_en", 64'(mem_en), 64'(|exp_gnt));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid", 64'(core_rvalid), 64'(e[W-1:DW]));
            chk("rdata", 64'(core_rdata), 64'(e[DW-1:0]));
        end else begin
            chk("rvalid_idle", 64'(core_rvalid), 64'(0));
        end
        if (!r && (exp_gnt & ~we) != '0) begin
            exp_q.push_back({exp_gnt, exp_rd});
        end
        @(posedge clk); #1;
    endtask

    logic [AW-1:0]   z_a;
    logic [N*AW-1:0] rd_a;
    logic [N*DW-1:0] z_d;
    logic [DW-1:0]   rd_vals [N];

    initial begin
        z_a  = '0;
        z_d  = '0;
        rd_a = pa(16'h0020, 16'h0021, 16'h0022, 16'h0023);
        rd_vals[0] = 8'h11; rd_vals[1] = 8'h22; rd_vals[2] = 8'h33; rd_vals[3] = 8'h44;

        rst = 1'b1; core_req = '0; core_we = '0; core_lock = '0;
        core_addr = '0; core_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        @(posedge clk); #1;
        bd_write(16'h0010, 8'h5A);
        for (int i = 0; i < N; i++) bd_write(16'h0020 + 16'(i), rd_vals[i]);

        tag = "reset";
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, rd_a, z_d, 4'b0000, 8'h00);
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, rd_a, z_d, 4'b0000, 8'h00);

        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, pa(z_a, z_a, 16'h0010, z_a), z_d, 4'b0100, 8'h5A));
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, rd_a, z_d, 4'b1000, 8'h44));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, rd_a, z_d, 4'(1 << (i % N)), rd_vals[i % N]));
        end
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, rd_a, z_d, 4'b0000, 8'h00));
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, pa(z_a, 16'h0100, z_a, z_a),
                          pd(8'h00, 8'hC3, 8'h00, 8'h00), 4'b0010, 8'h00));
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, pa(z_a, z_a, z_a, 16'h0100), z_d, 4'b1000, 8'hC3));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b0000, 4'b0000, rd_a, z_d, 4'b0010, 8'h22));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b0000, 4'b0000, rd_a, z_d, 4'b1000, 8'h44));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, rd_a, z_d, 4'b0000, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("vec%0d", i);
            step(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].lock,
                 vecs[i].addr, vecs[i].wdata, vecs[i].gnt, vecs[i].rd);
        end

        tag = "lock";
        step(1'b0, 4'b1111, 4'b0001, 4'b0001, pa(16'h0200, 16'h0021, 16'h0022, 16'h0023),
             pd(8'hA1, 8'h00, 8'h00, 8'h00), 4'b0001, 8'h00);
        step(1'b0, 4'b1111, 4'b0001, 4'b0001, pa(16'h0201, 16'h0021, 16'h0022, 16'h0023),
             pd(8'hA2, 8'h00, 8'h00, 8'h00), 4'b0001, 8'h00);
        step(1'b0, 4'b1111, 4'b0001, 4'b0000, pa(16'h0202, 16'h0021, 16'h0022, 16'h0023),
             pd(8'hA3, 8'h00, 8'h00, 8'h00), 4'b0001, 8'h00);
        step(1'b0, 4'b1110, 4'b0000, 4'b0000, rd_a, z_d, 4'b0010, 8'h22);
        step(1'b0, 4'b1100, 4'b0000, 4'b0000, rd_a, z_d, 4'b0100, 8'h33);
        step(1'b0, 4'b1000, 4'b0000, 4'b0000, rd_a, z_d, 4'b1000, 8'h44);
        step(1'b0, 4'b0100, 4'b0000, 4'b0000, pa(z_a, z_a, 16'h0201, z_a), z_d, 4'b0100, 8'hA2);

        tag = "lock_idle";
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, pa(z_a, z_a, 16'h0202, z_a), z_d, 4'b0100, 8'hA3);
        step(1'b0, 4'b0001, 4'b0000, 4'b0100, pa(16'h0010, z_a, z_a, z_a), z_d, 4'b0000, 8'h00);
        step(1'b0, 4'b0001, 4'b0000, 4'b0100, pa(16'h0010, z_a, z_a, z_a), z_d, 4'b0000, 8'h00);
        step(1'b0, 4'b0101, 4'b0000, 4'b0000, pa(16'h0010, z_a, 16'h0020, z_a), z_d, 4'b0100, 8'h11);
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, pa(16'h0010, z_a, z_a, z_a), z_d, 4'b0001, 8'h5A);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, rd_a, z_d, 4'b0000, 8'h00);

        tag = "reset_mid_read";
        step(1'b0, 4'b1000, 4'b0000, 4'b1000, rd_a, z_d, 4'b1000, 8'h44);
        step(1'b1, 4'b1011, 4'b0000, 4'b1000, rd_a, z_d, 4'b0000, 8'h00);
        step(1'b1, 4'b1011, 4'b0000, 4'b1000, rd_a, z_d, 4'b0000, 8'h00);
        step(1'b0, 4'b1010, 4'b0000, 4'b0000, rd_a, z_d, 4'b0010, 8'h22);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, rd_a, z_d, 4'b0000, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
